// File: rtl/leds_pkg.sv
// leds_pkg: register map, response code and field widths shared by the leds_v1 AXI4-Lite LED peripheral.
package leds_pkg;

    localparam logic [3:0] ADDR_LED_DATA   = 4'h0;
    localparam logic [3:0] ADDR_LED_TOGGLE = 4'h4;
    localparam logic [3:0] ADDR_INFO       = 4'h8;
    localparam logic [3:0] ADDR_SCRATCH    = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int INFO_W = 8;

    typedef enum logic [1:0] {
        REG_LED_DATA   = ADDR_LED_DATA[3:2],
        REG_LED_TOGGLE = ADDR_LED_TOGGLE[3:2],
        REG_INFO       = ADDR_INFO[3:2],
        REG_SCRATCH    = ADDR_SCRATCH[3:2]
    } reg_idx_t;

    function automatic reg_idx_t word_index(input logic [3:0] byte_addr);
        return reg_idx_t'(byte_addr[3:2]);
    endfunction

endpackage

// File: rtl/leds_axil_if.sv
// leds_axil_if: AXI4-Lite slave handshake engine; turns bus transactions into single-cycle
// register write/read strobes with a latched word index.
module leds_axil_if
    import leds_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                wr_en,
    output logic [1:0]          wr_idx,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    output logic                rd_en,
    output logic [1:0]          rd_idx,
    input  logic [DATA_W-1:0]   rd_data
);

    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              aw_en_q, aw_en_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        awidx_q, awidx_d;
    logic              arready_q, arready_d;
    logic [1:0]        aridx_q, aridx_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic wr_accept;
    logic wr_fire;
    logic rd_accept;

    // Write channel: AW and W are only taken together, and aw_en blocks a new
    // accept until the previous response has been consumed.
    always_comb begin
        wr_accept = awvalid & wvalid & ~awready_q & aw_en_q;
        wr_fire   = awready_q & wready_q;

        awready_d = wr_accept;
        wready_d  = wr_accept;
        awidx_d   = awidx_q;
        aw_en_d   = aw_en_q;
        bvalid_d  = bvalid_q;

        if (wr_accept) begin
            awidx_d = word_index(awaddr[3:0]);
            aw_en_d = 1'b0;
        end else if (bvalid_q && bready) begin
            aw_en_d = 1'b1;
        end

        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read channel: one read in flight; rdata is captured on the arready cycle
    // so it reflects register contents before any write landing on the same edge.
    always_comb begin
        rd_accept = arvalid & ~arready_q & ~rvalid_q;

        arready_d = rd_accept;
        aridx_d   = aridx_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        if (rd_accept) begin
            aridx_d = word_index(araddr[3:0]);
        end

        if (arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_en_q   <= 1'b1;
            bvalid_q  <= 1'b0;
            awidx_q   <= 2'b00;
            arready_q <= 1'b0;
            aridx_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_en_q   <= aw_en_d;
            bvalid_q  <= bvalid_d;
            awidx_q   <= awidx_d;
            arready_q <= arready_d;
            aridx_q   <= aridx_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bresp   = RESP_OKAY;
    assign bvalid  = bvalid_q;
    assign arready = arready_q;
    assign rdata   = rdata_q;
    assign rresp   = RESP_OKAY;
    assign rvalid  = rvalid_q;

    assign wr_en   = wr_fire;
    assign wr_idx  = awidx_q;
    assign wr_data = wdata;
    assign wr_strb = wstrb;
    assign rd_en   = arready_q;
    assign rd_idx  = aridx_q;

    logic unused_if;
    assign unused_if = &{1'b0, awaddr, araddr};

endmodule

// File: rtl/leds_v1.sv
// leds_v1: AXI4-Lite LED peripheral with LED_DATA, LED_TOGGLE, INFO and SCRATCH registers.
// Build option: define LEDS_ACTIVE_LOW_EN to drive the leds output inverted (active-low boards).
module leds_v1
    import leds_pkg::*;
#(
    parameter int C_NUM_OF_LEDS        = 4,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    output logic [C_NUM_OF_LEDS-1:0]            leds,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready
);

    localparam int DATA_W = C_S00_AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int N      = C_NUM_OF_LEDS;

`ifdef LEDS_ACTIVE_LOW_EN
    localparam logic [N-1:0] LED_POLARITY = '1;
`else
    localparam logic [N-1:0] LED_POLARITY = '0;
`endif

    // Reset asserts asynchronously but releases two clocks later, synchronously.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    logic              wr_en;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              rd_en;
    logic [1:0]        rd_idx;
    logic [DATA_W-1:0] rd_word;

    leds_axil_if #(
        .DATA_W (DATA_W),
        .ADDR_W (C_S00_AXI_ADDR_WIDTH)
    ) u_axil_if (
        .clk     (s00_axi_aclk),
        .rst_n   (rst_n),
        .awaddr  (s00_axi_awaddr),
        .awvalid (s00_axi_awvalid),
        .awready (s00_axi_awready),
        .wdata   (s00_axi_wdata),
        .wstrb   (s00_axi_wstrb),
        .wvalid  (s00_axi_wvalid),
        .wready  (s00_axi_wready),
        .bresp   (s00_axi_bresp),
        .bvalid  (s00_axi_bvalid),
        .bready  (s00_axi_bready),
        .araddr  (s00_axi_araddr),
        .arvalid (s00_axi_arvalid),
        .arready (s00_axi_arready),
        .rdata   (s00_axi_rdata),
        .rresp   (s00_axi_rresp),
        .rvalid  (s00_axi_rvalid),
        .rready  (s00_axi_rready),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_word)
    );

    logic [DATA_W-1:0] byte_mask;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte_mask
        assign byte_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end

    logic [N-1:0]      led_data_q, led_data_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [N-1:0]      leds_q, leds_d;

    // Toggle writes only flip bits whose byte lane is enabled.
    always_comb begin
        led_data_d = led_data_q;
        scratch_d  = scratch_q;
        if (wr_en) begin
            case (reg_idx_t'(wr_idx))
                REG_LED_DATA:   led_data_d = (led_data_q & ~byte_mask[N-1:0])
                                           | (wr_data[N-1:0] & byte_mask[N-1:0]);
                REG_LED_TOGGLE: led_data_d = led_data_q ^ (wr_data[N-1:0] & byte_mask[N-1:0]);
                REG_SCRATCH:    scratch_d  = (scratch_q & ~byte_mask) | (wr_data & byte_mask);
                default:        ;
            endcase
        end
        leds_d = led_data_d ^ LED_POLARITY;
    end

    always_comb begin
        rd_word = '0;
        case (reg_idx_t'(rd_idx))
            REG_LED_DATA: rd_word[N-1:0]      = led_data_q;
            REG_INFO:     rd_word[INFO_W-1:0] = INFO_W'(N);
            REG_SCRATCH:  rd_word             = scratch_q;
            default:      ;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            led_data_q <= '0;
            scratch_q  <= '0;
            leds_q     <= LED_POLARITY;
        end else begin
            led_data_q <= led_data_d;
            scratch_q  <= scratch_d;
            leds_q     <= leds_d;
        end
    end

    assign leds = leds_q;

    logic unused_top;
    assign unused_top = &{1'b0, s00_axi_awprot, s00_axi_arprot, rd_en};

endmodule

// File: tb/tb_leds_v1.sv
// tb_leds_v1: self-checking bench for leds_v1 -- directed corner sequences, a vector table,
// and randomized register traffic checked against a register-map model.
module tb_leds_v1;

    localparam int NL  = 4;
    localparam int TMO = 20;

`ifdef LEDS_ACTIVE_LOW_EN
    localparam logic [NL-1:0] LED_INV = '1;
`else
    localparam logic [NL-1:0] LED_INV = '0;
`endif

    logic          clk;
    logic          aresetn;
    logic [NL-1:0] leds;
    logic [3:0]    awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [3:0]    araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_led;
    logic [31:0] m_scratch;

    leds_v1 dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .leds            (leds),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_check(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timed out after %0d cycles, expected handshake", name, TMO);
        end
    endtask

    // Register-map model: byte-lane writes, toggle as XOR, INFO read-only.
    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                case (addr[3:2])
                    2'd0: m_led[b*8 +: 8]     = data[b*8 +: 8];
                    2'd1: m_led[b*8 +: 8]     = m_led[b*8 +: 8] ^ data[b*8 +: 8];
                    2'd3: m_scratch[b*8 +: 8] = data[b*8 +: 8];
                    default: ;
                endcase
            end
        end
        m_led = m_led & ((32'd1 << NL) - 32'd1);
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        case (addr[3:2])
            2'd0:    return m_led;
            2'd1:    return 32'h0;
            2'd2:    return 32'(NL);
            default: return m_scratch;
        endcase
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < TMO) begin @(negedge clk); n++; end
        bound_check("wr_accept", n < TMO);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        bound_check("wr_resp", n < TMO);
        check("bresp", 32'(bresp), 32'h0);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        $display("wr addr=%h data=%h strb=%b leds=%h", addr, data, strb, leds);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        bound_check("rd_accept", n < TMO);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rvalid && n < TMO) begin @(negedge clk); n++; end
        bound_check("rd_data", n < TMO);
        data = rdata;
        check("rresp", 32'(rresp), 32'h0);
        @(posedge clk); #1;
        rready = 1'b0;
        $display("rd addr=%h data=%h", addr, data);
    endtask

    typedef struct {
        logic [3:0]    wa;
        logic [31:0]   wd;
        logic [3:0]    ws;
        logic [3:0]    ra;
        logic [31:0]   exp_rd;
        logic [NL-1:0] exp_led;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          n;
        int          pulses;
        int          split;
        logic [31:0] rd;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        // Expected results assume LED_DATA=4'h3, SCRATCH=32'h0000BEEF going in.
        vecs[0] = '{4'h0, 32'h000000F5, 4'b0001, 4'h0, 32'h00000005, 4'h5};
        vecs[1] = '{4'h4, 32'h0000000F, 4'b0000, 4'h0, 32'h00000005, 4'h5};
        vecs[2] = '{4'h4, 32'h00000003, 4'b0001, 4'h4, 32'h00000000, 4'h6};
        vecs[3] = '{4'h8, 32'hFFFFFFFF, 4'b1111, 4'h8, 32'h00000004, 4'h6};
        vecs[4] = '{4'hC, 32'h12345678, 4'b1100, 4'hC, 32'h1234BEEF, 4'h6};
        vecs[5] = '{4'hC, 32'hAABBCCDD, 4'b0100, 4'hC, 32'h12BBBEEF, 4'h6};
        vecs[6] = '{4'h0, 32'hFFFFFF00, 4'b1110, 4'h0, 32'h00000006, 4'h6};
        vecs[7] = '{4'h0, 32'h00000009, 4'b1111, 4'h0, 32'h00000009, 4'h9};
        vecs[8] = '{4'h4, 32'h0000000F, 4'b0001, 4'h0, 32'h00000006, 4'h6};

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state.
        repeat (10) @(negedge clk);
        check("rst_leds", 32'(leds), 32'(LED_INV));
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_readys", 32'({awready, wready, arready}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);

        // Valids held with bready low: one accept only, response stays pending.
        awaddr = 4'h0; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        pulses = 0; split = 0;
        repeat (3) begin
            @(negedge clk);
            if (awready && wready) pulses++;
            if (awready != wready) split++;
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_split", 32'(split), 32'd0);
        check("held_leds", 32'(leds), 32'(4'hF ^ LED_INV));
        check("held_bvalid", 32'(bvalid), 32'h1);
        $display("wr addr=0 data=0000000f held valids, bready low");

        wdata = 32'hA;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (awready || wready) pulses++;
        end
        check("blocked_pulses", 32'(pulses), 32'd0);
        check("blocked_leds", 32'(leds), 32'(4'hF ^ LED_INV));
        check("blocked_bvalid", 32'(bvalid), 32'h1);

        bready = 1'b1;
        @(negedge clk);
        check("bready_clears", 32'(bvalid), 32'h0);
        n = 0;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        bound_check("second_accept", n < TMO);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("second_leds", 32'(leds), 32'(4'hA ^ LED_INV));
        @(posedge clk); #1;
        bready = 1'b0;
        $display("wr addr=0 data=0000000a after response consumed");

        // Toggle, write-only readback.
        axi_write(4'h4, 32'h5, 4'hF);
        check("toggle_leds", 32'(leds), 32'(4'hF ^ LED_INV));
        axi_read(4'h4, rd);
        check("toggle_rd", rd, 32'h0);

        // INFO read with rready held low for 5 cycles.
        @(negedge clk);
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        bound_check("info_accept", n < TMO);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("info_rvalid_hold", 32'(rvalid), 32'h1);
            check("info_rdata_hold", rdata, 32'h4);
        end
        check("info_rresp", 32'(rresp), 32'h0);
        rready = 1'b1;
        @(negedge clk);
        check("info_rvalid_clr", 32'(rvalid), 32'h0);
        rready = 1'b0;
        $display("rd addr=8 data=00000004 with rready stall");

        // Byte strobes.
        axi_write(4'hC, 32'hDEADBEEF, 4'b0011);
        axi_read(4'hC, rd);
        check("scratch_strb", rd, 32'h0000BEEF);
        axi_write(4'h0, 32'h0, 4'b0000);
        check("zero_strb_leds", 32'(leds), 32'(4'hF ^ LED_INV));

        // Simultaneous read and write of LED_DATA: read sees the old value.
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 4'h0; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        bound_check("simul_accept", n < TMO);
        check("simul_arready", 32'(arready), 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("simul_rvalid", 32'(rvalid), 32'h1);
        check("simul_rdata", rdata, 32'hF);
        check("simul_leds", 32'(leds), 32'(4'h3 ^ LED_INV));
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        $display("wr+rd addr=0 data=00000003 read=%h", rdata);

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws);
            check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_led ^ LED_INV));
            axi_read(vecs[i].ra, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Randomized traffic against the register-map model.
        m_led = 32'h6;
        m_scratch = 32'h12BBBEEF;
        for (int i = 0; i < 120; i++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            s = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s);
                model_write(a, d, s);
                check("rand_leds", 32'(leds), 32'(m_led[NL-1:0] ^ LED_INV));
            end else begin
                axi_read(a, rd);
                check("rand_rd", rd, model_read(a));
            end
        end

        // Reset while a write response is pending.
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'hC; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        bound_check("rst_wr_accept", n < TMO);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", 32'(bvalid), 32'h1);
        check("pre_rst_leds", 32'(leds), 32'(4'hC ^ LED_INV));
        aresetn = 1'b0;
        #1;
        check("async_rst_bvalid", 32'(bvalid), 32'h0);
        check("async_rst_leds", 32'(leds), 32'(LED_INV));
        check("async_rst_rdata", rdata, 32'h0);
        $display("async reset with pending response");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leds_v1.md
Name: leds_v1

Overview:
AXI4-Lite slave peripheral that drives a bank of discrete board LEDs from a memory-mapped control register. It sits on the PS/PL interconnect as a 16-byte register window. Software writes LED patterns; the block registers them and drives the `leds` output continuously.

Parameters:
C_NUM_OF_LEDS, 4, number of LED outputs (1..32).
C_S00_AXI_DATA_WIDTH, 32, AXI data width (32 only).
C_S00_AXI_ADDR_WIDTH, 4, AXI byte-address width; 4 word registers.

Ports:
s00_axi_aclk  in  1  single clock for all logic.
s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
leds  out  C_NUM_OF_LEDS  LED drive, registered.
s00_axi_awaddr  in  ADDR_W  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
s00_axi_wdata  in  DATA_W  write data.
s00_axi_wstrb  in  DATA_W/8  byte enables.
s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
s00_axi_bresp  out  2  always 2'b00 (OKAY).
s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
s00_axi_araddr  in  ADDR_W  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
s00_axi_rdata  out  DATA_W  read data.
s00_axi_rresp  out  2  always 2'b00.
s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.

Behaviour:
- Reset (aresetn=0, asynchronous): all readys, bvalid and rvalid are 0; rdata is 0; all registers are 0; leds=0. Deassertion is synchronised internally with a 2-flop synchroniser.
- Register map, decoded on addr[3:2]:
  - 0x0 LED_DATA: RW; bits [C_NUM_OF_LEDS-1:0] drive leds; upper bits read 0.
  - 0x4 LED_TOGGLE: WO, reads 0; each written 1 toggles the matching LED_DATA bit.
  - 0x8 INFO: RO; [7:0]=C_NUM_OF_LEDS, [31:8]=0; writes ignored.
  - 0xC SCRATCH: RW; full 32 bits.
- wstrb applies per byte on RW registers; on LED_TOGGLE, disabled bytes do not toggle.
- Write handshake:
  - Accept when awvalid & wvalid & ~awready & aw_en. awready and wready pulse high together for exactly 1 cycle.
  - The register updates on the following edge; leds reflects the new value one cycle after the accept cycle.
  - bvalid rises with the register update and holds until bready=1.
  - aw_en clears on accept and sets on bvalid&bready. No new write is accepted while a response is pending.
  - AW or W alone is never accepted.
  - Valids held high after acceptance must not cause a second write.
- Read handshake:
  - arready pulses 1 cycle when arvalid & ~arready & ~rvalid.
  - rvalid and rdata are registered the next cycle and held stable until rready=1.
  - One outstanding read at a time.
- Simultaneous read and write are processed independently. A read of LED_DATA in the same cycle as a write returns the pre-write value.
- Reset mid-transaction: the transaction is aborted, all valids drop, registers go to 0.

Optional Feature:
LEDS_ACTIVE_LOW_EN
- Defined: leds = ~LED_DATA[C_NUM_OF_LEDS-1:0], so the reset state is all-ones (LEDs off on active-low boards).
- Undefined: leds = LED_DATA directly.
- Register readback is the un-inverted LED_DATA in both cases.

Decomposition:
- Package leds_pkg: register offset constants (ADDR_LED_DATA, ADDR_LED_TOGGLE, ADDR_INFO, ADDR_SCRATCH), OKAY response constant, and an info-field width constant.
- Sub-module leds_axil_if: the AXI4-Lite handshake engine. It outputs a write strobe, word index, data and strb, plus a read strobe and index, and takes rdata in.
- The top level holds the register file and the LED output logic.

Test Plan:
- Reset: hold aresetn=0 for 10 cycles -> leds=0, bvalid=rvalid=0, all readys 0.
- Write 0xF to 0x0 with awvalid/wvalid held 3 cycles and bready=0 -> exactly one awready/wready pulse; leds=4'hF; bvalid stays 1. A second write of 0xA is then not accepted. Raise bready -> bvalid drops. Write 0xA -> leds=4'hA.
- Write 0x5 to 0x4 with LED_DATA=0xA -> leds=4'hF; a read of 0x4 returns 0.
- Read 0x8 -> rdata=32'h4, rresp=0. rvalid holds for 5 cycles with rready=0, then clears the cycle after rready=1.
- Write 0xDEADBEEF to 0xC with wstrb=4'b0011 on a zero register -> a read returns 32'h0000BEEF. A write with wstrb=0 to 0x0 leaves leds unchanged.
- Assert aresetn=0 while bvalid is pending -> bvalid and leds go to 0 asynchronously (all-ones under LEDS_ACTIVE_LOW_EN).
